// File: rtl/aes_pkg.sv
// Shared types and constants for the AES SPI framing front-end.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0]  DIR_ENC = 8'h00;
  localparam logic [7:0]  DIR_DEC = 8'hFF;
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned DIR_W   = 8;
  localparam int unsigned STAT_W  = 8;

  typedef struct packed {
    logic       dec;
    logic       k256;
    logic       k192;
    logic       err;
    logic [3:0] rsvd;
  } status_t;

  // Frame length: optional direction byte, message block, key.
  function automatic int unsigned frame_bits(input int unsigned k, input int unsigned inv);
    return (inv == 32'd2) ? (DIR_W + BLK_W + k) : (BLK_W + k);
  endfunction

endpackage

// File: rtl/sck_sync.sv
// Synchronises sck/sdi/load into clk and produces aligned edge pulses.
// All outputs share a latency of SYNC+1 clk from the pins.
module sck_sync #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck_i,
  input  logic sdi_i,
  input  logic load_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic sdi_o,
  output logic load_rise_o,
  output logic load_fall_o
);

  logic [SYNC-1:0] sck_q, sdi_q, load_q;
  logic            sck_p_q, load_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q       <= '0;
      sdi_q       <= '0;
      load_q      <= '0;
      sck_p_q     <= 1'b0;
      load_p_q    <= 1'b0;
      sck_rise_o  <= 1'b0;
      sck_fall_o  <= 1'b0;
      sdi_o       <= 1'b0;
      load_rise_o <= 1'b0;
      load_fall_o <= 1'b0;
    end else begin
      sck_q       <= {sck_q[SYNC-2:0], sck_i};
      sdi_q       <= {sdi_q[SYNC-2:0], sdi_i};
      load_q      <= {load_q[SYNC-2:0], load_i};
      sck_p_q     <= sck_q[SYNC-1];
      load_p_q    <= load_q[SYNC-1];
      sck_rise_o  <= sck_q[SYNC-1] & ~sck_p_q;
      sck_fall_o  <= ~sck_q[SYNC-1] & sck_p_q;
      sdi_o       <= sdi_q[SYNC-1];
      load_rise_o <= load_q[SYNC-1] & ~load_p_q;
      load_fall_o <= ~load_q[SYNC-1] & load_p_q;
    end
  end

endmodule

// File: rtl/aes_spi_frame.sv
// SPI-slave framing front-end for an AES core: shift in {dir, msg, key}, hand off, shift out result.
// Optional status byte ahead of the result when AES_SPI_STATUS_EN is defined.
module aes_spi_frame
  import aes_pkg::*;
#(
  parameter int unsigned K    = 128,
  parameter int unsigned INV  = 2,
  parameter int unsigned SYNC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             load,
  output logic             sdo,
  output logic             done,
  output logic             core_start,
  output logic [K-1:0]     core_key,
  output logic [BLK_W-1:0] core_msg,
  output logic             core_dec,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_result
);

  localparam int unsigned FRAME = frame_bits(K, INV);
  localparam int unsigned CW    = $clog2(FRAME + 2);
`ifdef AES_SPI_STATUS_EN
  localparam int unsigned OUTW  = BLK_W + STAT_W;
`else
  localparam int unsigned OUTW  = BLK_W;
`endif

  logic sck_rise, sck_fall, sdi_s, load_rise, load_fall;

  sck_sync #(.SYNC(SYNC)) u_sync (
    .clk         (clk),
    .reset       (reset),
    .sck_i       (sck),
    .sdi_i       (sdi),
    .load_i      (load),
    .sck_rise_o  (sck_rise),
    .sck_fall_o  (sck_fall),
    .sdi_o       (sdi_s),
    .load_rise_o (load_rise),
    .load_fall_o (load_fall)
  );

  state_e           state_q, state_d;
  logic [FRAME-1:0] sreg_q, sreg_d, sreg_nx;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
  logic [OUTW-1:0]  out_q, out_d, res_val;
  logic             sdo_q, sdo_d, done_q, done_d, start_q, start_d, dec_q, dec_d;
  logic [K-1:0]     key_q, key_d;
  logic [BLK_W-1:0] msg_q, msg_d;
  logic [DIR_W-1:0] dir_b;
  logic             dir_ok, dec_nx;

`ifdef AES_SPI_STATUS_EN
  status_t status;
  logic    err_q, err_d;

  always_comb begin
    status      = '0;
    status.dec  = dec_q;
    status.k256 = (K == 32'd256);
    status.k192 = (K == 32'd192);
    status.err  = err_q;
  end

  assign res_val = {status, core_result};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  assign res_val = core_result;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      start_q <= start_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
    end
  end

  // Shift step applied before the length check so a coincident sck edge counts.
  always_comb begin
    sreg_nx = sreg_q;
    cnt_nx  = cnt_q;
    if (state_q == SHIFT && sck_rise) begin
      sreg_nx = {sreg_q[FRAME-2:0], sdi_s};
      if (cnt_q < CW'(FRAME + 1)) cnt_nx = cnt_q + CW'(1);
    end
    dir_b = sreg_nx[FRAME-1 -: DIR_W];
    if (INV == 32'd2) begin
      dir_ok = (dir_b == DIR_ENC) || (dir_b == DIR_DEC);
      dec_nx = (dir_b == DIR_DEC);
    end else begin
      dir_ok = 1'b1;
      dec_nx = (INV == 32'd1);
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sdo_d   = sdo_q;
    done_d  = done_q;
    start_d = 1'b0;
    dec_d   = dec_q;
    key_d   = key_q;
    msg_d   = msg_q;
`ifdef AES_SPI_STATUS_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_rise) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_nx;
        cnt_d  = cnt_nx;
        if (load_fall) begin
          if (cnt_nx == CW'(FRAME) && dir_ok) begin
            key_d   = sreg_nx[K-1:0];
            msg_d   = sreg_nx[K +: BLK_W];
            dec_d   = dec_nx;
            start_d = 1'b1;
            state_d = BUSY;
          end else begin
`ifdef AES_SPI_STATUS_EN
            err_d   = 1'b1;
`endif
            state_d = IDLE;
          end
        end
      end
      BUSY: begin
        if (load_rise) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (core_done) begin
          sdo_d   = res_val[OUTW-1];
          out_d   = res_val << 1;
          done_d  = 1'b1;
          cnt_d   = '0;
`ifdef AES_SPI_STATUS_EN
          err_d   = 1'b0;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (load_rise) begin
          done_d  = 1'b0;
          sdo_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (sck_fall) begin
          // cnt counts falls already taken; the last fall ends the read-out.
          if (cnt_q == CW'(OUTW - 1)) begin
            done_d  = 1'b0;
            sdo_d   = 1'b0;
            state_d = IDLE;
          end else begin
            sdo_d = out_q[OUTW-1];
            out_d = out_q << 1;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sdo        = sdo_q;
  assign done       = done_q;
  assign core_start = start_q;
  assign core_key   = key_q;
  assign core_msg   = msg_q;
  assign core_dec   = dec_q;

endmodule

// File: tb/tb_aes_spi_frame.sv
// Scoreboard bench for aes_spi_frame: three instances (K=128/INV=2, K=192/INV=2, K=256/INV=0).
module tb_aes_spi_frame;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 5;
`ifdef AES_SPI_STATUS_EN
  localparam int unsigned OUTW = 136;
`else
  localparam int unsigned OUTW = 128;
`endif

  logic clk = 1'b0;
  logic reset, sck, sdi;
  logic load_v [3];
  logic done_v [3];
  logic sdo_v [3];
  logic start_v [3];
  logic dec_v [3];
  logic [127:0] msg_v [3];
  logic [255:0] key_v [3];
  logic err_v [3];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int           inst;
    logic [255:0] key;
    logic [127:0] msg;
    logic         dec;
  } req_t;

  typedef struct {
    int           inst;
    logic [135:0] val;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];

  localparam logic [255:0] KEY_A = 256'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] MSG_A = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] RES_A = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [255:0] KEY_B = 256'h000102030405060708090A0B0C0D0E0F1011121314151617;
  localparam logic [127:0] MSG_B = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] RES_B = 128'hDDA97CA4864CDFE06EAF70A0EC0D7191;
  localparam logic [255:0] KEY_C = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] RES_C = 128'h8EA2B7CA516745BFEAFC49904B496089;

  always #5 clk = ~clk;

  // Cipher core stand-in: known FIPS-197 vectors, otherwise a simple mixing function.
  function automatic logic [127:0] core_fn(input logic [255:0] key, input logic [127:0] msg, input logic dec);
    if (key == KEY_A && msg == MSG_A && dec)  return RES_A;
    if (key == KEY_B && msg == MSG_B && !dec) return RES_B;
    if (key == KEY_C && msg == MSG_B && !dec) return RES_C;
    return msg ^ key[127:0] ^ key[255:128] ^ {128{dec}};
  endfunction

  function automatic int unsigned kbits(input int g);
    return (g == 0) ? 128 : ((g == 1) ? 192 : 256);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned KK = (g == 0) ? 128 : ((g == 1) ? 192 : 256);
    localparam int unsigned II = (g == 2) ? 0 : 2;
    logic [KK-1:0]  key_w;
    logic           cdone_w;
    logic [127:0]   res_w;
    logic [135:0]   sh;
    int             nb;
    req_t           e;
    res_t           r;

    assign key_v[g] = 256'(key_w);

    aes_spi_frame #(.K(KK), .INV(II), .SYNC(SYNC)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .sck         (sck),
      .sdi         (sdi),
      .load        (load_v[g]),
      .sdo         (sdo_v[g]),
      .done        (done_v[g]),
      .core_start  (start_v[g]),
      .core_key    (key_w),
      .core_msg    (msg_v[g]),
      .core_dec    (dec_v[g]),
      .core_done   (cdone_w),
      .core_result (res_w)
    );

    initial begin
      logic [127:0] rr;
      cdone_w = 1'b0;
      res_w   = '0;
      forever begin
        @(negedge clk);
        if (start_v[g] === 1'b1) begin
          rr = core_fn(key_v[g], msg_v[g], dec_v[g]);
          repeat (6) @(negedge clk);
          res_w   = rr;
          cdone_w = 1'b1;
          @(negedge clk);
          cdone_w = 1'b0;
          res_w   = '0;
        end
      end
    end

    // Request monitor: every core_start must match the oldest pending frame.
    always @(negedge clk) begin
      if (start_v[g] === 1'b1) begin
        if (req_q.size() == 0 || req_q[0].inst != g) begin
          n_vec++;
          n_err++;
          $display("FAIL u%0d unexpected core_start: got 1 expected 0", g);
        end else begin
          e = req_q.pop_front();
          check($sformatf("u%0d core_key", g), key_v[g], e.key);
          check($sformatf("u%0d core_msg", g), 256'(msg_v[g]), 256'(e.msg));
          check($sformatf("u%0d core_dec", g), 256'(dec_v[g]), 256'(e.dec));
        end
      end
    end

    // Result monitor: collect sdo on sck rise while done; partial reads are dropped.
    initial begin
      sh = '0;
      nb = 0;
    end
    always @(posedge sck) begin
      if (done_v[g] !== 1'b1) begin
        nb = 0;
      end else begin
        sh = {sh[134:0], sdo_v[g]};
        nb++;
        if (nb == int'(OUTW)) begin
          nb = 0;
          if (res_q.size() == 0 || res_q[0].inst != g) begin
            n_vec++;
            n_err++;
            $display("FAIL u%0d unexpected result: got %0h expected none", g, sh);
          end else begin
            r = res_q.pop_front();
            check($sformatf("u%0d result", g), 256'(sh[OUTW-1:0]), 256'(r.val[OUTW-1:0]));
          end
        end
      end
    end
  end

  task automatic sck_pulse();
    repeat (HALF) @(negedge clk);
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic shift_frame(input int g, input logic [391:0] fr, input int nbits);
    load_v[g] = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = fr[i];
      sck_pulse();
    end
    repeat (HALF) @(negedge clk);
    load_v[g] = 1'b0;
    sdi = 1'b0;
    repeat (SYNC + 8) @(negedge clk);
  endtask

  task automatic send(input int g, input logic [7:0] dir, input logic [127:0] msg,
                      input logic [255:0] key, input int trim, input bit ok, input bit rd,
                      input logic [127:0] exp_res);
    int unsigned k;
    logic [391:0] fr;
    int nbits;
    req_t q;
    res_t rs;
    logic [7:0] st;
    k  = kbits(g);
    fr = '0;
    if (g != 2) fr = 392'(dir);
    fr = (fr << 128) | 392'(msg);
    fr = (fr << k) | 392'(key);
    nbits = ((g != 2) ? 8 : 0) + 128 + int'(k) - trim;
    if (ok) begin
      q.inst = g;
      q.key  = key;
      q.msg  = msg;
      q.dec  = (g != 2) && (dir == 8'hFF);
      req_q.push_back(q);
      st = {q.dec, k == 256, k == 192, err_v[g], 4'h0};
      err_v[g] = 1'b0;
      if (rd) begin
        rs.inst = g;
        rs.val  = {st, exp_res};
        res_q.push_back(rs);
      end
    end else begin
      err_v[g] = 1'b1;
    end
    shift_frame(g, fr, nbits);
  endtask

  task automatic wait_done(input int g);
    int t;
    t = 0;
    while (done_v[g] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("u%0d done rise", g), 256'(done_v[g]), 256'(1'b1));
  endtask

  task automatic read_out(input int g);
    wait_done(g);
    repeat (OUTW) sck_pulse();
    repeat (SYNC + 4) @(negedge clk);
    check($sformatf("u%0d done after read", g), 256'(done_v[g]), 256'(1'b0));
    check($sformatf("u%0d sdo after read", g), 256'(sdo_v[g]), 256'(1'b0));
  endtask

  task automatic check_zero(input int g, input string tag);
    check($sformatf("u%0d %s done", g, tag), 256'(done_v[g]), '0);
    check($sformatf("u%0d %s sdo", g, tag), 256'(sdo_v[g]), '0);
    check($sformatf("u%0d %s start", g, tag), 256'(start_v[g]), '0);
    check($sformatf("u%0d %s key", g, tag), key_v[g], '0);
    check($sformatf("u%0d %s msg", g, tag), 256'(msg_v[g]), '0);
    check($sformatf("u%0d %s dec", g, tag), 256'(dec_v[g]), '0);
  endtask

  initial begin
    reset = 1'b1;
    sck   = 1'b0;
    sdi   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_v[i] = 1'b0;
      err_v[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Decrypt via dir byte, K=128
    send(0, 8'hFF, MSG_A, KEY_A, 0, 1'b1, 1'b1, RES_A);
    read_out(0);

    // Encrypt via dir byte, K=192
    send(1, 8'h00, MSG_B, KEY_B, 0, 1'b1, 1'b1, RES_B);
    read_out(1);

    // K=256 fixed encrypt: one-bit-short frame is dropped, next frame completes
    send(2, 8'h00, MSG_B, KEY_C, 1, 1'b0, 1'b0, '0);
    check("u2 done after short frame", 256'(done_v[2]), '0);
    send(2, 8'h00, MSG_B, KEY_C, 0, 1'b1, 1'b1, RES_C);
    read_out(2);

    // Illegal dir byte
    send(0, 8'h5A, MSG_B, KEY_A, 0, 1'b0, 1'b0, '0);
    check("u0 done after bad dir", 256'(done_v[0]), '0);
    send(0, 8'h00, MSG_B, KEY_A, 0, 1'b1, 1'b1, core_fn(KEY_A, MSG_B, 1'b0));
    read_out(0);

    // Abort after 40 result bits, then a fresh frame
    send(0, 8'hFF, MSG_A, KEY_A, 0, 1'b1, 1'b0, '0);
    wait_done(0);
    repeat (40) sck_pulse();
    load_v[0] = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    check("u0 done after abort", 256'(done_v[0]), '0);
    check("u0 sdo after abort", 256'(sdo_v[0]), '0);
    send(0, 8'h00, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, KEY_A, 0, 1'b1, 1'b1,
         core_fn(KEY_A, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b0));
    read_out(0);

    // Reset mid-SHIFT
    load_v[1] = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      sdi = i[0];
      sck_pulse();
    end
    reset = 1'b1;
    #1;
    check_zero(1, "mid-shift reset");
    load_v[1] = 1'b0;
    sdi = 1'b0;
    for (int i = 0; i < 3; i++) err_v[i] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-DONE, then a clean frame
    send(1, 8'h00, MSG_A, KEY_B, 0, 1'b1, 1'b0, '0);
    wait_done(1);
    repeat (10) sck_pulse();
    reset = 1'b1;
    #1;
    check_zero(1, "mid-done reset");
    for (int i = 0; i < 3; i++) err_v[i] = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(1, 8'hFF, MSG_B, KEY_B, 0, 1'b1, 1'b1, core_fn(KEY_B, MSG_B, 1'b1));
    read_out(1);

    repeat (20) @(negedge clk);
    check("pending core requests", 256'(req_q.size()), '0);
    check("pending results", 256'(res_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
